// File: rtl/cordic_vector_phase_if.sv
// Handshake and result bundle for the CORDIC vectoring phase/magnitude block.
interface cordic_vector_phase_if;
    logic               in_valid;
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic               in_ready;
    logic               out_valid;
    logic [11:0]        theta;
    logic [17:0]        mag;

    modport master (output in_valid, re, im, input in_ready, out_valid, theta, mag);
    modport slave  (input in_valid, re, im, output in_ready, out_valid, theta, mag);
endinterface

// File: rtl/cordic_vector_phase.sv
// Iterative CORDIC vectoring: atan2(im, re) as a 12-bit phase plus gain-scaled
// magnitude, one micro-rotation per clock, 14 iterations per sample.
module cordic_vector_phase (
    input  logic                  clk,
    input  logic                  rst_n,
    cordic_vector_phase_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, ITER = 1'b1} state_t;

    state_t             state, state_next;
    logic signed [17:0] x, y, x_it, y_it, x_sh, y_sh, re_ext, im_ext;
    logic [15:0]        z, z_it, z_rnd, angle;
    logic [3:0]         count;
    logic               zero, accept, last;
    logic               out_valid_r;
    logic [11:0]        theta_r;
    logic [17:0]        mag_r;

    assign accept = (state == IDLE) && bus.in_valid;
    assign last   = (state == ITER) && (count == 4'd13);
    assign re_ext = {{2{bus.re[15]}}, bus.re};
    assign im_ext = {{2{bus.im[15]}}, bus.im};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.in_valid)      state_next = ITER;
            ITER: if (count == 4'd13)    state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = out_valid_r;
        bus.theta     = theta_r;
        bus.mag       = mag_r;
    end

    // atan(2^-i) with 2*pi = 65536
    always_comb begin
        case (count)
            4'd0:    angle = 16'd8192;
            4'd1:    angle = 16'd4836;
            4'd2:    angle = 16'd2555;
            4'd3:    angle = 16'd1297;
            4'd4:    angle = 16'd651;
            4'd5:    angle = 16'd326;
            4'd6:    angle = 16'd163;
            4'd7:    angle = 16'd81;
            4'd8:    angle = 16'd41;
            4'd9:    angle = 16'd20;
            4'd10:   angle = 16'd10;
            4'd11:   angle = 16'd5;
            4'd12:   angle = 16'd3;
            4'd13:   angle = 16'd1;
            default: angle = 16'd0;
        endcase
    end

    always_comb begin
        x_sh = x >>> count;
        y_sh = y >>> count;
        if (!y[17]) begin
            x_it = x + y_sh;
            y_it = y - x_sh;
            z_it = z + angle;
        end else begin
            x_it = x - y_sh;
            y_it = y + x_sh;
            z_it = z - angle;
        end
        // 16-bit wrap makes a phase that rounds up to 4096 land on 0
        z_rnd = z_it + 16'd8;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x           <= '0;
            y           <= '0;
            z           <= '0;
            count       <= '0;
            zero        <= 1'b0;
            out_valid_r <= 1'b0;
            theta_r     <= '0;
            mag_r       <= '0;
        end else begin
            out_valid_r <= last;
            if (accept) begin
                // Fold the left half-plane into CORDIC's convergence range
                if (bus.re[15]) begin
                    x <= -re_ext;
                    y <= -im_ext;
                    z <= 16'h8000;
                end else begin
                    x <= re_ext;
                    y <= im_ext;
                    z <= 16'h0000;
                end
                count <= 4'd0;
                zero  <= (bus.re == 16'sd0) && (bus.im == 16'sd0);
            end else if (state == ITER) begin
                x     <= x_it;
                y     <= y_it;
                z     <= z_it;
                count <= count + 4'd1;
                if (last) begin
                    theta_r <= zero ? 12'd0 : z_rnd[15:4];
                    mag_r   <= zero ? 18'd0 : x_it;
                end
            end
        end
    end
endmodule

// File: tb/tb_cordic_vector_phase.sv
// Directed bench for cordic_vector_phase: axes, magnitude, corners, handshake,
// mid-computation reset and a full phase sweep.
module tb_cordic_vector_phase;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    cordic_vector_phase_if bus ();

    cordic_vector_phase dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int cdist(input logic [11:0] a, input int b);
        int d;
        d = (int'(a) - b) & 4095;
        return (d > 2048) ? 4096 - d : d;
    endfunction

    // Launch one sample and wait for its result; lat = falling edges from
    // acceptance to the out_valid cycle, -1 on timeout.
    task automatic do_op(input logic signed [15:0] r, input logic signed [15:0] i,
                         output logic [11:0] th, output logic [17:0] mg, output int lat);
        bit found;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.re       = r;
        bus.im       = i;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat   = 0;
        found = 1'b0;
        while (lat < 40 && !found) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid === 1'b1) found = 1'b1;
        end
        th = bus.theta;
        mg = bus.mag;
        if (!found) lat = -1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.re       = '0;
        bus.im       = '0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        if (bus.theta !== 12'd0) begin errors++; $display("FAIL reset_theta got %0d want 0", bus.theta); end
        if (bus.mag !== 18'd0) begin errors++; $display("FAIL reset_mag got %0d want 0", bus.mag); end
        rst_n = 1'b1;
    endtask

    task automatic test_axes();
        logic signed [15:0] rv [4] = '{16384, 0, -16384, 0};
        logic signed [15:0] iv [4] = '{0, 16384, 0, -16384};
        int                 ev [4] = '{0, 1024, 2048, 3072};
        logic [11:0] th;
        logic [17:0] mg;
        int          lat;
        for (int k = 0; k < 4; k++) begin
            do_op(rv[k], iv[k], th, mg, lat);
            checks += 2;
            if (cdist(th, ev[k]) > 1) begin errors++; $display("FAIL axis%0d_theta got %0d want %0d+-1", k, th, ev[k]); end
            if (lat != 15) begin errors++; $display("FAIL axis%0d_latency got %0d want 15", k, lat); end
        end
    endtask

    task automatic test_magnitude();
        logic [11:0] th;
        logic [17:0] mg;
        int          lat;
        do_op(16'sd11585, 16'sd11585, th, mg, lat);
        checks += 2;
        if (cdist(th, 512) > 1) begin errors++; $display("FAIL diag_theta got %0d want 512+-1", th); end
        if (int'(mg) < 26976 || int'(mg) > 26984) begin errors++; $display("FAIL diag_mag got %0d want 26980+-4", mg); end
        do_op(16'sd16384, 16'sd0, th, mg, lat);
        checks++;
        if (int'(mg) < 26976 || int'(mg) > 26984) begin errors++; $display("FAIL axis_mag got %0d want 26980+-4", mg); end
    endtask

    task automatic test_corners();
        logic [11:0] th;
        logic [17:0] mg;
        int          lat;
        do_op(16'sd0, 16'sd0, th, mg, lat);
        checks += 2;
        if (th !== 12'd0) begin errors++; $display("FAIL zero_theta got %0d want 0", th); end
        if (mg !== 18'd0) begin errors++; $display("FAIL zero_mag got %0d want 0", mg); end
        do_op(-16'sd32768, 16'sd0, th, mg, lat);
        checks += 2;
        if (cdist(th, 2048) > 1) begin errors++; $display("FAIL negfull_theta got %0d want 2048+-1", th); end
        // 32768 * 1.64676 = 53961
        if (int'(mg) < 53945 || int'(mg) > 53977) begin errors++; $display("FAIL negfull_mag got %0d want ~53961", mg); end
        do_op(16'sd32767, -16'sd1, th, mg, lat);
        checks++;
        if (th !== 12'd4095 && th !== 12'd0) begin errors++; $display("FAIL nearwrap_theta got %0d want 4095 or 0", th); end
    endtask

    task automatic test_back_to_back();
        int          pulses = 0;
        logic [11:0] held_th;
        logic [17:0] held_mg;
        bit          exp_rdy, exp_ov;
        int          exp_th;
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            exp_rdy = (j % 15 == 0) || (j > 45);
            exp_ov  = (j == 15) || (j == 30) || (j == 45);
            checks += 2;
            if (bus.in_ready !== exp_rdy) begin errors++; $display("FAIL b2b_in_ready cycle %0d got %b want %b", j, bus.in_ready, exp_rdy); end
            if (bus.out_valid !== exp_ov) begin errors++; $display("FAIL b2b_out_valid cycle %0d got %b want %b", j, bus.out_valid, exp_ov); end
            if (bus.out_valid === 1'b1) begin
                pulses++;
                exp_th = (j == 15) ? 0 : (j == 30) ? 1024 : 2048;
                checks++;
                if (cdist(bus.theta, exp_th) > 1) begin errors++; $display("FAIL b2b_theta cycle %0d got %0d want %0d+-1", j, bus.theta, exp_th); end
            end
            if (j == 15) begin held_th = bus.theta; held_mg = bus.mag; end
            if (j == 29) begin
                checks++;
                if (bus.theta !== held_th || bus.mag !== held_mg) begin
                    errors++;
                    $display("FAIL b2b_hold got %0d/%0d want %0d/%0d", bus.theta, bus.mag, held_th, held_mg);
                end
            end
            // Only cycles 0, 15, 30 should be taken; everything else aims at 3072
            bus.in_valid = (j < 40);
            case (j)
                0:       begin bus.re = 16'sd16384;  bus.im = 16'sd0;      end
                15:      begin bus.re = 16'sd0;      bus.im = 16'sd16384;  end
                30:      begin bus.re = -16'sd16384; bus.im = 16'sd0;      end
                default: begin bus.re = 16'sd0;      bus.im = -16'sd16384; end
            endcase
        end
        bus.in_valid = 1'b0;
        checks++;
        if (pulses != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", pulses); end
    endtask

    task automatic test_reset_mid();
        int          stray = 0;
        logic [11:0] th;
        logic [17:0] mg;
        int          lat;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.re       = 16'sd0;
        bus.im       = 16'sd16384;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks += 4;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", bus.out_valid); end
        if (bus.theta !== 12'd0) begin errors++; $display("FAIL midrst_theta got %0d want 0", bus.theta); end
        if (bus.mag !== 18'd0) begin errors++; $display("FAIL midrst_mag got %0d want 0", bus.mag); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) stray++;
        end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL midrst_stray got %0d pulses want 0", stray); end
        do_op(16'sd16384, 16'sd0, th, mg, lat);
        checks++;
        if (cdist(th, 0) > 1 || lat != 15) begin errors++; $display("FAIL midrst_recover got theta %0d lat %0d want 0+-1 lat 15", th, lat); end
    endtask

    task automatic test_sweep();
        logic [11:0] th;
        logic [17:0] mg;
        int          lat;
        real         ang;
        for (int t = 0; t < 4096; t++) begin
            ang = 2.0 * 3.14159265358979 * real'(t) / 4096.0;
            do_op(16'(int'(16384.0 * $cos(ang))), 16'(int'(16384.0 * $sin(ang))), th, mg, lat);
            checks++;
            if (cdist(th, t) > 1 || lat != 15) begin
                errors++;
                $display("FAIL sweep theta_in %0d got %0d lat %0d want %0d+-1 lat 15", t, th, lat, t);
            end
            if (t % 256 == 0) $display("sweep theta_in=%0d theta=%0d mag=%0d", t, th, mg);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.re       = '0;
        bus.im       = '0;
        test_reset();
        test_axes();
        test_magnitude();
        test_corners();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cordic_vector_phase.md
CORDIC_VECTOR_PHASE -- requirements
Module: cordic_vector_phase

Interface
REQ-001 Parameters: none; all widths below are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  re/im valid this cycle.
REQ-005 re  input  16  signed cosine component, two's complement, full-scale ±32767.
REQ-006 im  input  16  signed sine component, two's complement.
REQ-007 in_ready  output  1  block can accept an input (high only in IDLE).
REQ-008 out_valid  output  1  one-cycle pulse; theta/mag valid.
REQ-009 theta  output  12  unsigned phase; LSB = 2π/4096, so 0=0 rad, 1024=π/2, 2048=π, 3072=3π/2.
REQ-010 mag  output  18  unsigned magnitude, CORDIC-gain scaled: mag ≈ 1.64676·sqrt(re²+im²).

Function
REQ-011 The block SHALL compute theta = atan2(im, re) by iterative CORDIC vectoring, one micro-rotation per clock.
REQ-012 The block SHALL implement states IDLE and ITER: IDLE→ITER on a rising edge with in_valid=1; ITER→IDLE on the edge that completes iteration 13.
REQ-013 On the IDLE→ITER edge the block SHALL pre-rotate: if re<0 then x=-re, y=-im, z=32768; otherwise x=re, y=im, z=0; set count=0.
REQ-014 x and y SHALL be 18-bit signed; z SHALL be a 16-bit unsigned accumulator with LSB = 2π/65536 and wrap mod 65536.
REQ-015 Each ITER edge, for i=count: if y≥0 then x+=y>>>i, y-=x>>>i, z+=A[i]; else x-=y>>>i, y+=x>>>i, z-=A[i]; count+=1. All right-hand sides SHALL use pre-edge values, with arithmetic shifts.
REQ-016 A[0..13] SHALL be the constants 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1.
REQ-017 On the edge completing iteration 13 the block SHALL register theta = ((z+8)>>4) mod 4096 and mag = x[17:0] as unsigned, and assert out_valid for exactly the following cycle.
REQ-018 Latency: in_valid sampled at edge k SHALL produce out_valid=1 in the cycle after edge k+14; throughput is one result per 15 cycles.
REQ-019 in_valid while in_ready=0 SHALL be ignored; the in-flight computation SHALL NOT be disturbed.
REQ-020 In the out_valid cycle in_ready=1, so a new input SHALL be accepted back-to-back.
REQ-021 re=0 and im=0 SHALL yield theta=0 and mag=0. This is a latched zero flag, not the CORDIC result.
REQ-022 re=-32768 SHALL negate to +32768 without overflow, given the 18-bit x.
REQ-023 Between out_valid pulses, theta and mag SHALL hold their last values.
REQ-024 Phase near 2π SHALL wrap: a z that rounds to 4096 SHALL output 0.

Reset
REQ-025 While rst_n=0: state=IDLE, in_ready=1, out_valid=0, theta=0, mag=0, and x, y, z, count, zero flag all 0.
REQ-026 Reset asserted mid-ITER SHALL abort the computation; no out_valid SHALL follow deassertion.
REQ-027 The first input SHALL be accepted on the first rising edge with rst_n=1 and in_valid=1.

Verification
REQ-028 Axes: (re,im) = (16384,0)→theta 0; (0,16384)→1024; (-16384,0)→2048; (0,-16384)→3072. Tolerance ±1 LSB; each out_valid exactly 15 cycles after acceptance.
REQ-029 Diagonal and magnitude: (11585,11585)→theta 512±1, mag 26980±4; (16384,0)→mag 26980±4.
REQ-030 Sweep: for theta_in 0..4095, drive re=round(16384·cos), im=round(16384·sin) → theta equals theta_in ±1 mod 4096. Result values are printed for the MATLAB plot.
REQ-031 Handshake: pulse in_valid every cycle for 40 cycles → exactly 3 results, from the inputs at cycles 0, 15 and 30 only, with in_ready low during ITER.
REQ-032 Zero and corner inputs: (0,0)→theta 0, mag 0; (-32768,0)→theta 2048±1 with no overflow; (32767,-1)→theta 4095 or 0.
REQ-033 Reset: assert rst_n=0 at iteration 7 → all outputs 0 immediately, no out_valid after release, and the next input completes normally.
